// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-approach rotating phase controller with
// pedestrian WALK/flash, emergency pre-emption and a seconds countdown.
// Ports: CLK_50MHz, reset (sync, active-high), hold (freeze timers),
//   ped_req/em_req [N_DIR] in; car_g/car_y/car_r/ped_walk [N_DIR],
//   ped_flash, active_dir, remain[8], em_active, phase_tick out.
// Macro TRAFFIC_PED_EN: when defined, pedestrian logic is built.
module traffic_phase_ctrl #(
  parameter int N_DIR    = 4,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int PED_T    = 15,
  parameter int FLASH_T  = 5,
  parameter int TICK_MOD = 25000000
) (
  input  logic                       CLK_50MHz,
  input  logic                       reset,
  input  logic                       hold,
  input  logic [N_DIR-1:0]           ped_req,
  input  logic [N_DIR-1:0]           em_req,
  output logic [N_DIR-1:0]           car_g,
  output logic [N_DIR-1:0]           car_y,
  output logic [N_DIR-1:0]           car_r,
  output logic [N_DIR-1:0]           ped_walk,
  output logic                       ped_flash,
  output logic [$clog2(N_DIR)-1:0]   active_dir,
  output logic [7:0]                 remain,
  output logic                       em_active,
  output logic                       phase_tick
);

  localparam int DW = $clog2(N_DIR);
  localparam int PW = (TICK_MOD > 1) ? $clog2(TICK_MOD) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_MOD - 1);
  localparam logic [7:0] G8 = 8'(GREEN_T);
  localparam logic [7:0] Y8 = 8'(YELLOW_T);
  localparam logic [7:0] R8 = 8'(ALLRED_T);
  localparam logic [N_DIR-1:0] ONE = N_DIR'(1);

  typedef enum logic [2:0] {
    S_GREEN, S_YELLOW, S_ALLRED,
    S_EM_YELLOW, S_EM_ALLRED, S_EM_GREEN,
    S_EM_EXIT_Y, S_EM_EXIT_R
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dir_q, dir_d, dir_nx;
  logic [DW-1:0]   em_e_q, em_e_d, em_sel;
  logic [7:0]      remain_q, remain_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [N_DIR-1:0] em_q, onehot_d, g_d, y_d;
  logic            em_act_q, em_act_d;
  logic            em_any, accept, tick, last;
  logic            green_entry;

  assign active_dir = dir_q;
  assign remain     = remain_q;
  assign em_active  = em_act_q;

  // Lowest-index emergency request wins.
  always_comb begin
    em_any = 1'b0;
    em_sel = '0;
    for (int i = N_DIR - 1; i >= 0; i--) begin
      if (em_q[i]) begin
        em_any = 1'b1;
        em_sel = DW'(i);
      end
    end
  end

  assign tick   = !hold && (presc_q == PMAX);
  assign last   = tick && (remain_q == 8'd1);
  assign dir_nx = (dir_q == DW'(N_DIR - 1)) ? '0 : dir_q + 1'b1;
  // em_act_q already set means a pre-emption is in flight.
  assign accept = em_any && !em_act_q;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    remain_d    = remain_q;
    em_e_d      = em_e_q;
    em_act_d    = em_act_q;
    green_entry = 1'b0;
    presc_d     = presc_q;
    if (!hold) presc_d = tick ? '0 : presc_q + 1'b1;
    if (tick && state_q != S_EM_GREEN) remain_d = remain_q - 8'd1;
    unique case (state_q)
      S_GREEN: begin
        if (accept) begin
          em_act_d = 1'b1;
          em_e_d   = em_sel;
          presc_d  = '0;
          if (em_sel == dir_q) begin
            state_d  = S_EM_GREEN;
            remain_d = '0;
          end else begin
            state_d  = S_EM_YELLOW;
            remain_d = Y8;
          end
        end else if (last) begin
          state_d  = S_YELLOW;
          remain_d = Y8;
        end
      end
      S_YELLOW: begin
        if (accept) begin
          em_act_d = 1'b1;
          em_e_d   = em_sel;
        end
        if (last) begin
          state_d  = S_ALLRED;
          remain_d = R8;
        end
      end
      S_ALLRED: begin
        if (accept) begin
          em_act_d = 1'b1;
          em_e_d   = em_sel;
        end
        if (last && em_act_d) begin
          state_d  = S_EM_ALLRED;
          remain_d = R8;
        end else if (last) begin
          state_d     = S_GREEN;
          dir_d       = dir_nx;
          remain_d    = G8;
          green_entry = 1'b1;
        end
      end
      S_EM_YELLOW: begin
        if (last) begin
          state_d  = S_EM_ALLRED;
          remain_d = R8;
        end
      end
      S_EM_ALLRED: begin
        if (last) begin
          state_d  = S_EM_GREEN;
          dir_d    = em_e_q;
          remain_d = '0;
        end
      end
      S_EM_GREEN: begin
        if (!em_q[em_e_q]) begin
          state_d  = S_EM_EXIT_Y;
          remain_d = Y8;
          presc_d  = '0;
        end
      end
      S_EM_EXIT_Y: begin
        if (last) begin
          state_d  = S_EM_EXIT_R;
          remain_d = R8;
        end
      end
      S_EM_EXIT_R: begin
        if (last) begin
          state_d     = S_GREEN;
          dir_d       = dir_nx;
          remain_d    = G8;
          em_act_d    = 1'b0;
          green_entry = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    onehot_d = ONE << dir_d;
    g_d = '0;
    y_d = '0;
    if (state_d == S_GREEN || state_d == S_EM_GREEN)
      g_d = onehot_d;
    if (state_d == S_YELLOW || state_d == S_EM_YELLOW ||
        state_d == S_EM_EXIT_Y)
      y_d = onehot_d;
  end

  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      state_q    <= S_GREEN;
      dir_q      <= '0;
      remain_q   <= G8;
      presc_q    <= '0;
      em_q       <= '0;
      em_e_q     <= '0;
      em_act_q   <= 1'b0;
      phase_tick <= 1'b0;
      car_g      <= ONE;
      car_y      <= '0;
      car_r      <= ~ONE;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      remain_q   <= remain_d;
      presc_q    <= presc_d;
      em_q       <= em_req;
      em_e_q     <= em_e_d;
      em_act_q   <= em_act_d;
      phase_tick <= (state_d != state_q) || (dir_d != dir_q);
      car_g      <= g_d;
      car_y      <= y_d;
      car_r      <= ~(g_d | y_d);
    end
  end

`ifdef TRAFFIC_PED_EN
  localparam logic [7:0] WALK_END  = 8'(GREEN_T - PED_T);
  localparam logic [7:0] FLASH_END = 8'(GREEN_T - PED_T + FLASH_T);

  logic [N_DIR-1:0] ped_q, pend_q, pend_d;
  logic             walk_q, walk_d;

  // A request seen on the entry edge itself is kept for the next visit.
  always_comb begin
    pend_d = pend_q;
    walk_d = walk_q;
    if (green_entry && pend_q[dir_d]) begin
      pend_d[dir_d] = 1'b0;
      walk_d        = 1'b1;
    end
    pend_d = pend_d | ped_q;
    if (state_d != S_GREEN || remain_d <= WALK_END)
      walk_d = 1'b0;
  end

  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      ped_q     <= '0;
      pend_q    <= '0;
      walk_q    <= 1'b0;
      ped_walk  <= '0;
      ped_flash <= 1'b0;
    end else begin
      ped_q     <= ped_req;
      pend_q    <= pend_d;
      walk_q    <= walk_d;
      ped_walk  <= walk_d ? onehot_d : '0;
      ped_flash <= walk_d && (remain_d <= FLASH_END);
    end
  end
`else
  logic unused_ped;
  assign unused_ped = ^{ped_req, green_entry};
  assign ped_walk   = '0;
  assign ped_flash  = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: scoreboard bench for traffic_phase_ctrl.
// Stimulus queues expected output events; a monitor pops on change.
module tb_traffic_phase_ctrl;

`ifdef TRAFFIC_PED_EN
  localparam bit PED_ON = 1'b1;
`else
  localparam bit PED_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hold = 1'b0;
  logic [3:0] ped_req = '0;
  logic [3:0] em_req = '0;
  logic [3:0] car_g, car_y, car_r, ped_walk;
  logic       ped_flash, em_active, phase_tick;
  logic [1:0] active_dir;
  logic [7:0] remain;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] g, y, r, w;
    logic       f, pt;
    logic [1:0] d;
    logic [7:0] rem;
    logic       em;
  } obs_t;

  obs_t       sb[$];
  bit         mon_en = 1'b0;
  bit         mon_primed = 1'b0;
  logic [7:0] prev_rem;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .N_DIR(4), .GREEN_T(6), .YELLOW_T(2), .ALLRED_T(1),
    .PED_T(4), .FLASH_T(2), .TICK_MOD(4)
  ) dut (
    .CLK_50MHz(clk), .reset(reset), .hold(hold),
    .ped_req(ped_req), .em_req(em_req),
    .car_g(car_g), .car_y(car_y), .car_r(car_r),
    .ped_walk(ped_walk), .ped_flash(ped_flash),
    .active_dir(active_dir), .remain(remain),
    .em_active(em_active), .phase_tick(phase_tick)
  );

  // kind: 0 green, 1 yellow, 2 all red
  function automatic obs_t mk(int kind, int d, int rem,
                              bit w, bit f, bit pt, bit em);
    obs_t o;
    logic [3:0] oh;
    oh    = 4'b0001 << d;
    o.g   = (kind == 0) ? oh : 4'b0000;
    o.y   = (kind == 1) ? oh : 4'b0000;
    o.r   = ~(o.g | o.y);
    o.w   = (w && PED_ON) ? oh : 4'b0000;
    o.f   = f && PED_ON;
    o.pt  = pt;
    o.d   = 2'(d);
    o.rem = 8'(rem);
    o.em  = em;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.g = car_g; o.y = car_y; o.r = car_r;
    o.w = ped_walk; o.f = ped_flash; o.pt = phase_tick;
    o.d = active_dir; o.rem = remain; o.em = em_active;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("g=%b y=%b r=%b walk=%b flash=%b pt=%b dir=%0d rem=%0d em=%b",
                     o.g, o.y, o.r, o.w, o.f, o.pt, o.d, o.rem, o.em);
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got [%s] required [%s]", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic expect_empty(string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events still pending, required 0",
               name, sb.size());
    end
    sb.delete();
  endtask

  // Events during one visit to d, ending with the next green entry.
  task automatic push_dir(int d, bit w, bit wn);
    sb.push_back(mk(0, d, 5, w, 0, 0, 0));
    sb.push_back(mk(0, d, 4, w, w, 0, 0));
    sb.push_back(mk(0, d, 3, w, w, 0, 0));
    sb.push_back(mk(0, d, 2, 0, 0, 0, 0));
    sb.push_back(mk(0, d, 1, 0, 0, 0, 0));
    sb.push_back(mk(1, d, 2, 0, 0, 1, 0));
    sb.push_back(mk(1, d, 1, 0, 0, 0, 0));
    sb.push_back(mk(2, d, 1, 0, 0, 1, 0));
    sb.push_back(mk(0, (d + 1) % 4, 6, wn, 0, 1, 0));
  endtask

  task automatic monitor();
    obs_t a;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        a = sample();
        if (!mon_primed) begin
          prev_rem   = remain;
          mon_primed = 1'b1;
        end else begin
          checks++;
          if ((car_g | car_y | car_r) !== 4'hF ||
              ((car_g & car_y) | (car_g & car_r) | (car_y & car_r)) !== 4'h0) begin
            errors++;
            $display("FAIL lamps: g=%b y=%b r=%b, required one lamp per approach",
                     car_g, car_y, car_r);
          end
          if (phase_tick || remain !== prev_rem) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL event: unexpected [%s], required no change", fmt(a));
            end else begin
              check("event", a, sb.pop_front());
            end
          end
          prev_rem = remain;
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge reset is released.
  task automatic do_reset();
    mon_en  = 1'b0;
    reset   = 1'b1;
    hold    = 1'b0;
    ped_req = '0;
    em_req  = '0;
    repeat (2) @(negedge clk);
    check("reset", sample(), mk(0, 0, 6, 0, 0, 0, 0));
    reset      = 1'b0;
    mon_primed = 1'b0;
    mon_en     = 1'b1;
  endtask

  initial begin
    fork
      monitor();
    join_none
    @(negedge clk);

    // Full rotation G0..G3 back to G0.
    do_reset();
    for (int d = 0; d < 4; d++) push_dir(d, 1'b0, 1'b0);
    repeat (146) @(negedge clk);
    expect_empty("rotation");

    // Ped pulse on 0 and 2 during G0: walk on G2, then next G0 only.
    do_reset();
    push_dir(0, 0, 0); push_dir(1, 0, 1);
    push_dir(2, 1, 0); push_dir(3, 0, 1);
    push_dir(0, 1, 0); push_dir(1, 0, 0);
    push_dir(2, 0, 0); push_dir(3, 0, 0);
    repeat (2) @(negedge clk);
    ped_req = 4'b0101;
    @(negedge clk);
    ped_req = 4'b0000;
    repeat (287) @(negedge clk);
    expect_empty("pedestrian");

    // Cross-approach pre-emption from G0 to approach 3.
    do_reset();
    sb.push_back(mk(0, 0, 5, 0, 0, 0, 0));
    sb.push_back(mk(1, 0, 2, 0, 0, 1, 1));
    sb.push_back(mk(1, 0, 1, 0, 0, 0, 1));
    sb.push_back(mk(2, 0, 1, 0, 0, 1, 1));
    sb.push_back(mk(0, 3, 0, 0, 0, 1, 1));
    sb.push_back(mk(1, 3, 2, 0, 0, 1, 1));
    sb.push_back(mk(1, 3, 1, 0, 0, 0, 1));
    sb.push_back(mk(2, 3, 1, 0, 0, 1, 1));
    sb.push_back(mk(0, 0, 6, 0, 0, 1, 0));
    repeat (5) @(negedge clk);
    em_req = 4'b1000;
    repeat (94) @(negedge clk);
    em_req = 4'b0000;
    repeat (16) @(negedge clk);
    expect_empty("preempt_cross");

    // Own-approach pre-emption during WALK, then mid-phase reset.
    do_reset();
    push_dir(0, 0, 1);
    sb.push_back(mk(0, 1, 5, 1, 0, 0, 0));
    sb.push_back(mk(0, 1, 0, 0, 0, 1, 1));
    repeat (2) @(negedge clk);
    ped_req = 4'b0010;
    @(negedge clk);
    ped_req = 4'b0000;
    repeat (38) @(negedge clk);
    em_req = 4'b0010;
    @(negedge clk);
    check("em_own_latency", sample(), mk(0, 1, 5, 1, 0, 0, 0));
    @(negedge clk);
    check("em_own_entry", sample(), mk(0, 1, 0, 0, 0, 1, 1));
    repeat (2) @(negedge clk);
    expect_empty("preempt_own");
    mon_en = 1'b0;
    reset  = 1'b1;
    em_req = 4'b0000;
    @(negedge clk);
    check("mid_reset", sample(), mk(0, 0, 6, 0, 0, 0, 0));
    reset = 1'b0;

    // Hold for 10 ticks in the middle of Y2.
    @(negedge clk);
    do_reset();
    push_dir(0, 0, 0); push_dir(1, 0, 0); push_dir(2, 0, 0);
    repeat (97) @(negedge clk);
    hold = 1'b1;
    repeat (13) @(negedge clk);
    check("hold_a", sample(), mk(1, 2, 2, 0, 0, 0, 0));
    repeat (20) @(negedge clk);
    check("hold_b", sample(), mk(1, 2, 2, 0, 0, 0, 0));
    repeat (7) @(negedge clk);
    hold = 1'b0;
    repeat (13) @(negedge clk);
    expect_empty("hold");

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised N-approach intersection phase controller. It generates the car lamps, pedestrian WALK/flash and a seconds-remaining count for a rotating green phase. It also handles latched pedestrian requests and emergency pre-emption with safe yellow and all-red clearance. It replaces fixed 4-way signal sequencing and feeds the existing warning, simulation and 7-segment display blocks.

## Interface
- `N_DIR`, 4: number of approaches, 2..8.
- `GREEN_T`, 20: green duration in seconds, 2..255.
- `YELLOW_T`, 3: yellow duration in seconds, 1..255.
- `ALLRED_T`, 1: all-red clearance in seconds, 1..255.
- `PED_T`, 15: WALK duration in seconds; must satisfy PED_T ≤ GREEN_T.
- `FLASH_T`, 5: ped flash window, i.e. the last FLASH_T seconds of WALK.
- `TICK_MOD`, 25000000: clock cycles per timer tick.
- `CLK_50MHz`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `hold`  in  1  level; freezes the prescaler and `remain`; the state is held.
- `ped_req`  in  N_DIR  level or pulse; pedestrian button per approach.
- `em_req`  in  N_DIR  level; emergency vehicle present on the approach.
- `car_g`, `car_y`, `car_r`  out  N_DIR each  one-hot lamps per approach, registered.
- `ped_walk`  out  N_DIR  WALK lamp per approach.
- `ped_flash`  out  1  high while any WALK is in its flash window.
- `active_dir`  out  $clog2(N_DIR)  approach currently owning the phase.
- `remain`  out  8  seconds left in the current state; 0 during EM_GREEN.
- `em_active`  out  1  high from pre-emption accept until resume.
- `phase_tick`  out  1  one-cycle pulse on every state change.

## Operation
- **Prescaler:** counts 0..TICK_MOD-1 and asserts `tick` for one cycle at TICK_MOD-1. `hold` freezes the count.
- **States:** GREEN, YELLOW, ALLRED, EM_YELLOW, EM_ALLRED, EM_GREEN, EM_EXIT_Y, EM_EXIT_R.
- **Normal rotation:**
  - GREEN(d), GREEN_T → YELLOW(d), YELLOW_T → ALLRED, ALLRED_T → GREEN((d+1) mod N_DIR).
  - `remain` is loaded with the full duration on entry. It decrements on `tick`. On a tick with `remain`==1 the machine transitions.
- **Lamps:**
  - `car_g[d]` in GREEN and EM_GREEN.
  - `car_y[d]` in YELLOW, EM_YELLOW and EM_EXIT_Y.
  - Every other approach, and every approach in any ALLRED state, shows `car_r`.
  - Exactly one lamp per approach is high in every cycle.
- **Pedestrian:**
  - A `ped_req[i]` sampled high sets `pend[i]`.
  - On GREEN(d) entry with `pend[d]` set: clear `pend[d]`, set `walk_on`, and drive `ped_walk[d]`=1 until GREEN_T−PED_T seconds remain' is reached.
  - `ped_flash`=1 while `walk_on` and the WALK has ≤FLASH_T seconds left.
  - A request arriving during the active GREEN(d) is held for the next visit to d.
- **Emergency:**
  - The lowest-index set bit of `em_req` is selected as e, and is sampled only in GREEN, YELLOW or ALLRED.
  - In GREEN(d) with d==e: enter EM_GREEN immediately; WALK is cancelled.
  - In GREEN(d) with d≠e: go to EM_YELLOW (YELLOW_T), then EM_ALLRED (ALLRED_T), then EM_GREEN(e).
  - In YELLOW or ALLRED: finish the running clearance with the normal durations, then EM_ALLRED(ALLRED_T), then EM_GREEN(e).
  - EM_GREEN(e) holds while `em_req[e]`=1. When it drops: EM_EXIT_Y, EM_EXIT_R, then GREEN((e+1) mod N_DIR). `em_active` clears on that GREEN entry.
  - Other `em_req` bits are ignored until resume.
- **Reset:**
  - State GREEN, `active_dir`=0, `remain`=GREEN_T.
  - Prescaler 0, `pend`=0.
  - `car_g`=1 on bit 0 only; `car_r` on all other bits; `car_y`=0.
  - `ped_walk`=0, `ped_flash`=0, `em_active`=0, `phase_tick`=0.

## Timing
- All outputs are registered and update in the cycle after the `tick` that causes the change. `phase_tick` is asserted in that same cycle.
- `em_req` or `ped_req` are registered once, which gives one cycle of input latency:
  - GREEN(d==e) pre-emption takes effect on the outputs 2 clocks after `em_req` rises, independent of `tick`.
  - EM_GREEN exit starts 2 clocks after `em_req[e]` falls.
- Pre-emption entry and exit load `remain` and restart the prescaler at 0.
- `hold` together with `em_req`: the pre-emption decision is still taken, but timers stay frozen.
- `reset` asserted mid-phase returns all outputs to their reset values on the next edge. `pend` is cleared.
- `remain` is never 0 outside EM_GREEN.

## Configuration
- `TRAFFIC_PED_EN` defined: pedestrian logic (`pend`, WALK, flash) is present.
- `TRAFFIC_PED_EN` undefined: `ped_req` is ignored; `ped_walk` is tied to 0 and `ped_flash` to 0. Car sequencing is unchanged.

## Test plan
All scenarios use N_DIR=4, TICK_MOD=4, GREEN_T=6, YELLOW_T=2, ALLRED_T=1, PED_T=4, FLASH_T=2.

- **Reset and rotation:** release reset and run 36 ticks → order G0(6)-Y0(2)-R(1)-G1, …, back to G0. Check one lamp per approach in every cycle and `phase_tick` exactly at each change.
- **Pedestrian:** pulse `ped_req[2]` one cycle during G0 → `ped_walk[2]` high for the first 4 s of G2. `ped_flash` is high for its last 2 s. A second G2 visit with no new request gives no WALK.
- **Pre-empt, cross approach:** raise `em_req[3]` at G0 with `remain`=5 → Y0 2 s, all-red 1 s, G3 held with `em_active`=1 for 20 ticks. On drop: Y3 2 s, R 1 s, then G0.
- **Pre-empt, own approach:** raise `em_req[1]` during G1 with WALK active → EM_GREEN 2 clocks later. `ped_walk`=0 and `remain`=0.
- **Hold:** assert `hold` for 10 ticks mid-Y2 → `remain` and lamps are unchanged. Sequencing resumes with the same `remain` value.
- **Mid-phase reset:** assert `reset` during EM_GREEN → G0, `remain`=6, `em_active`=0 on the next edge.
